// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared types, constants and last-word padding helper for the SHA-256 padder
package sha256_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int          BLOCK_WORDS = 16;
    localparam logic [31:0] PAD_MARK    = 32'h8000_0000;

    // Keeps the first nbytes bytes, drops in the 0x80 marker right after them and
    // zeroes the rest; a full word (4 or more) passes through untouched.
    function automatic logic [31:0] pad_last_word(input logic [31:0] data,
                                                  input logic [2:0]  nbytes);
        logic [31:0] w_word;
        case (nbytes)
            3'd0:    w_word = PAD_MARK;
            3'd1:    w_word = {data[31:24], 8'h80, 16'h0000};
            3'd2:    w_word = {data[31:16], 8'h80, 8'h00};
            3'd3:    w_word = {data[31:8],  8'h80};
            default: w_word = data;
        endcase
        return w_word;
    endfunction

endpackage

// File: rtl/sha256_padder.sv
// rtl/sha256_padder.sv - FIPS 180-4 message padder emitting 512-bit blocks with first/last flags
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_nbytes,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_last,
    output logic         busy
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_slot [BLOCK_WORDS];
    logic [4:0]         r_wctr;
    logic [LEN_W-1:0]   r_len;
    logic               r_mark_pend;
    logic               r_msg_done;
    logic               r_first;
    logic               r_last;

    logic               w_in_fire;
    logic               w_blk_fire;
    logic [2:0]         w_nb_eff;
    logic [4:0]         w_wctr_inc;
    logic               w_pad_len;
    logic [63:0]        w_len64;
    logic [LEN_W-1:0]   w_len_add;
    logic               w_wr_en;
    logic [3:0]         w_wr_idx;
    logic [31:0]        w_wr_word;

    assign in_ready   = reset_n && (r_state == FILL);
    assign blk_valid  = (r_state == OUT);
    assign blk_first  = r_first;
    assign blk_last   = r_last;
    assign busy       = (r_state != FILL) || (r_wctr != 5'd0);

    assign w_in_fire  = in_valid && in_ready;
    assign w_blk_fire = blk_valid && blk_ready;
    assign w_nb_eff   = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
    assign w_wctr_inc = r_wctr + 5'd1;
    assign w_pad_len  = (r_state == PAD) && (r_wctr == 5'd14) && !r_mark_pend;
    assign w_len_add  = in_last ? LEN_W'({w_nb_eff, 3'b000}) : LEN_W'(32);
    assign w_wr_idx   = r_wctr[3:0];

    always_comb begin
        w_len64            = '0;
        w_len64[LEN_W-1:0] = r_len;
    end

    // Single-slot write port shared by FILL (message words) and PAD (marker / zero fill).
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_word = '0;
        case (r_state)
            FILL: begin
                w_wr_en   = w_in_fire;
                w_wr_word = in_last ? pad_last_word(in_data, w_nb_eff) : in_data;
            end
            PAD: begin
                w_wr_en   = !w_pad_len;
                w_wr_word = r_mark_pend ? PAD_MARK : 32'h0;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL: begin
                if (w_in_fire) begin
                    if (w_wctr_inc == 5'd16) w_state_nxt = OUT;
                    else if (in_last)        w_state_nxt = PAD;
                end
            end
            PAD: begin
                if (w_pad_len || (r_wctr == 5'd15)) w_state_nxt = OUT;
            end
            OUT: begin
                if (w_blk_fire) begin
                    if (r_last)          w_state_nxt = FILL;
                    else if (r_msg_done) w_state_nxt = PAD;
                    else                 w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= FILL;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            if (!reset_n)                   r_slot[i] <= '0;
            else if (w_pad_len && i == 14)  r_slot[i] <= w_len64[63:32];
            else if (w_pad_len && i == 15)  r_slot[i] <= w_len64[31:0];
            else if (w_wr_en && w_wr_idx == 4'(i)) r_slot[i] <= w_wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wctr      <= '0;
            r_len       <= '0;
            r_mark_pend <= 1'b0;
            r_msg_done  <= 1'b0;
            r_first     <= 1'b1;
            r_last      <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_in_fire) begin
                        r_wctr <= w_wctr_inc;
                        r_len  <= r_len + w_len_add;
                        if (in_last) begin
                            r_mark_pend <= (w_nb_eff == 3'd4);
                            r_msg_done  <= 1'b1;
                        end
                    end
                end
                PAD: begin
                    if (w_pad_len) begin
                        r_last <= 1'b1;
                    end else begin
                        r_mark_pend <= 1'b0;
                        r_wctr      <= w_wctr_inc;
                    end
                end
                OUT: begin
                    if (w_blk_fire) begin
                        r_wctr  <= '0;
                        r_first <= 1'b0;
                        r_last  <= 1'b0;
                        if (r_last) begin
                            r_len      <= '0;
                            r_msg_done <= 1'b0;
                            r_first    <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            blk_data[511-32*i -: 32] = r_slot[i];
        end
    end

endmodule
